// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI read crossbar: response codes and per-target FSM state encoding.
// No logic; imported by the arbiter and the crossbar top.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } rresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } tgt_state_t;

endpackage

// File: rtl/axi_rd_target_arb.sv
// Per-target round-robin arbiter + IDLE/ADDR/DATA FSM; grant registered, 1 cycle after request.
// Back-pressure: AR waits on i_arready, R advances only on i_rready; DECERR mode generates its own beats.
module axi_rd_target_arb
    import axi_rd_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int LEN_W       = 4,
    parameter bit DECERR_MODE = 1'b0,
    localparam int GW         = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NUM_M-1:0] i_req,
    input  logic [LEN_W-1:0] i_arlen,
    input  logic             i_arready,
    input  logic             i_rvalid,
    input  logic             i_rlast,
    input  logic             i_rready,
    output logic [1:0]       o_state,
    output logic [GW-1:0]    o_gnt,
    output logic             o_arready,
    output logic             o_rvalid,
    output logic             o_rlast
);

    tgt_state_t       r_state;
    logic [GW-1:0]    r_gnt;
    logic [GW-1:0]    r_rr;
    logic [LEN_W-1:0] r_len;
    logic [4:0]       r_beat;
    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic             w_rvalid;
    logic             w_rlast;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_found && i_req[(int'(r_rr) + i) % NUM_M]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_rr) + i) % NUM_M);
            end
        end
    end

    // The decode-error target has no slave behind it: it is always valid and ends after ARLEN+1 beats.
    assign w_rvalid  = DECERR_MODE ? 1'b1 : i_rvalid;
    assign w_rlast   = DECERR_MODE ? (r_beat == 5'(r_len)) : i_rlast;
    assign o_rvalid  = (r_state == ST_DATA) & w_rvalid;
    assign o_rlast   = (r_state == ST_DATA) & w_rlast;
    assign o_arready = (r_state == ST_ADDR) & i_arready;
    assign o_state   = r_state;
    assign o_gnt     = r_gnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_rr    <= (w_pick == GW'(NUM_M - 1)) ? '0 : w_pick + 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (o_arready) begin
                        r_len   <= i_arlen;
                        r_beat  <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (o_rvalid && i_rready) begin
                        if (o_rlast) begin
                            r_beat  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 5'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_xbar_nxm.sv
// NUM_M x NUM_S AXI read crossbar (AR+R) with address decode and a DECERR target; AR issued 1 cycle after ARVALID.
// Back-pressure: AR and R handshakes pass combinationally between the granted master and its target.
module axi_rd_xbar_nxm
    import axi_rd_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                    G_clk,
    input  logic                    G_reset,
    input  logic [NUM_M*ADDR_W-1:0] M_ARADDR,
    input  logic [NUM_M*LEN_W-1:0]  M_ARLEN,
    input  logic [NUM_M*3-1:0]      M_ARSIZE,
    input  logic [NUM_M*2-1:0]      M_ARBURST,
    input  logic [NUM_M-1:0]        M_ARVALID,
    output logic [NUM_M-1:0]        M_ARREADY,
    output logic [NUM_M*DATA_W-1:0] M_RDATA,
    output logic [NUM_M*2-1:0]      M_RRESP,
    output logic [NUM_M-1:0]        M_RLAST,
    output logic [NUM_M-1:0]        M_RVALID,
    input  logic [NUM_M-1:0]        M_RREADY,
    output logic [NUM_S*ADDR_W-1:0] S_ARADDR,
    output logic [NUM_S*LEN_W-1:0]  S_ARLEN,
    output logic [NUM_S*3-1:0]      S_ARSIZE,
    output logic [NUM_S*2-1:0]      S_ARBURST,
    output logic [NUM_S-1:0]        S_ARVALID,
    input  logic [NUM_S-1:0]        S_ARREADY,
    input  logic [NUM_S*DATA_W-1:0] S_RDATA,
    input  logic [NUM_S*2-1:0]      S_RRESP,
    input  logic [NUM_S-1:0]        S_RLAST,
    input  logic [NUM_S-1:0]        S_RVALID,
    output logic [NUM_S-1:0]        S_RREADY,
    input  logic [NUM_S*ADDR_W-1:0] slave_base,
    input  logic [NUM_S*ADDR_W-1:0] slave_limit
);

    localparam int NT = NUM_S + 1;
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int TW = $clog2(NT);

    logic [TW-1:0]        w_tgt [NUM_M];
    logic [NUM_M-1:0]     w_busy;
    logic [NUM_M-1:0]     w_req [NT];
    logic [1:0]           w_st [NT];
    logic [GW-1:0]        w_gnt [NT];
    logic [LEN_W-1:0]     w_arlen [NT];
    logic [NT-1:0]        w_rready, w_arr, w_rvld, w_rlst;
    logic [NT-1:0]        w_sarready, w_srvalid, w_srlast;
    logic [NT*DATA_W-1:0] w_srdata;
    logic [NT*2-1:0]      w_srresp;

    // Target index NUM_S is the decode-error responder; pad the slave buses so it muxes like a slave.
    assign w_sarready = {1'b1, S_ARREADY};
    assign w_srvalid  = {1'b0, S_RVALID};
    assign w_srlast   = {1'b0, S_RLAST};
    assign w_srdata   = {{DATA_W{1'b0}}, S_RDATA};
    assign w_srresp   = {RESP_DECERR, S_RRESP};

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            w_tgt[m] = TW'(NUM_S);
            for (int s = NUM_S - 1; s >= 0; s--) begin
                if (M_ARADDR[m*ADDR_W +: ADDR_W] >= slave_base[s*ADDR_W +: ADDR_W] &&
                    M_ARADDR[m*ADDR_W +: ADDR_W] <= slave_limit[s*ADDR_W +: ADDR_W])
                    w_tgt[m] = TW'(s);
            end
        end
    end

    // A master is busy exactly while some target holds it outside IDLE.
    always_comb begin
        w_busy = '0;
        for (int t = 0; t < NT; t++)
            for (int m = 0; m < NUM_M; m++)
                if (w_st[t] != ST_IDLE && w_gnt[t] == GW'(m)) w_busy[m] = 1'b1;
    end

    always_comb begin
        for (int t = 0; t < NT; t++)
            for (int m = 0; m < NUM_M; m++)
                w_req[t][m] = M_ARVALID[m] & ~w_busy[m] & (w_tgt[m] == TW'(t));
    end

    for (genvar t = 0; t < NT; t++) begin : g_tgt
        assign w_arlen[t]  = M_ARLEN[w_gnt[t]*LEN_W +: LEN_W];
        assign w_rready[t] = M_RREADY[w_gnt[t]];

        axi_rd_target_arb #(
            .NUM_M       (NUM_M),
            .LEN_W       (LEN_W),
            .DECERR_MODE (t == NUM_S)
        ) u_arb (
            .i_clk     (G_clk),
            .i_reset   (G_reset),
            .i_req     (w_req[t]),
            .i_arlen   (w_arlen[t]),
            .i_arready (w_sarready[t]),
            .i_rvalid  (w_srvalid[t]),
            .i_rlast   (w_srlast[t]),
            .i_rready  (w_rready[t]),
            .o_state   (w_st[t]),
            .o_gnt     (w_gnt[t]),
            .o_arready (w_arr[t]),
            .o_rvalid  (w_rvld[t]),
            .o_rlast   (w_rlst[t])
        );
    end

    always_comb begin
        S_ARADDR  = '0;
        S_ARLEN   = '0;
        S_ARSIZE  = '0;
        S_ARBURST = '0;
        S_ARVALID = '0;
        S_RREADY  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (w_st[s] == ST_ADDR) begin
                S_ARVALID[s]                 = 1'b1;
                S_ARADDR[s*ADDR_W +: ADDR_W] = M_ARADDR[w_gnt[s]*ADDR_W +: ADDR_W];
                S_ARLEN[s*LEN_W +: LEN_W]    = M_ARLEN[w_gnt[s]*LEN_W +: LEN_W];
                S_ARSIZE[s*3 +: 3]           = M_ARSIZE[w_gnt[s]*3 +: 3];
                S_ARBURST[s*2 +: 2]          = M_ARBURST[w_gnt[s]*2 +: 2];
            end
            S_RREADY[s] = (w_st[s] == ST_DATA) & w_rready[s];
        end
    end

    always_comb begin
        M_ARREADY = '0;
        M_RVALID  = '0;
        M_RLAST   = '0;
        M_RDATA   = '0;
        M_RRESP   = '0;
        for (int t = 0; t < NT; t++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (w_gnt[t] == GW'(m)) begin
                    if (w_arr[t]) M_ARREADY[m] = 1'b1;
                    if (w_st[t] == ST_DATA) begin
                        M_RVALID[m]                 = w_rvld[t];
                        M_RLAST[m]                  = w_rlst[t];
                        M_RDATA[m*DATA_W +: DATA_W] = w_srdata[t*DATA_W +: DATA_W];
                        M_RRESP[m*2 +: 2]           = w_srresp[t*2 +: 2];
                    end
                end
            end
        end
    end

endmodule
